// File: rtl/nanorv32_dbg_apbif.sv
// APB debug controller for nanorv32: PC breakpoints, counted stepping, halt/resume FSM.
// Latency: writes commit in the APB setup cycle, reads are combinational; halt_req follows a match by 1 cycle.
// Backpressure: none; pready is tied 1 and pslverr is tied 0. Optional macro: NANORV32_DBG_HITCNT_EN (per-breakpoint hit counters).
module nanorv32_dbg_apbif #(
   parameter int NUM_BKPT   = 4,
   parameter int STEP_CNT_W = 16
) (
   input  logic                  clk_apb,
   input  logic                  rst_apb_n,
   input  logic                  apb_dbg_psel,
   input  logic [11:0]           apb_dbg_paddr,
   input  logic                  apb_dbg_penable,
   input  logic                  apb_dbg_pwrite,
   input  logic [31:0]           apb_dbg_pwdata,
   output logic [31:0]           dbg_apb_prdata,
   output logic                  dbg_apb_pready,
   output logic                  dbg_apb_pslverr,
   input  logic                  cpu_instr_valid,
   input  logic [31:0]           cpu_pc,
   output logic                  dbg_halt_req,
   output logic [NUM_BKPT-1:0]   dbg_bkpt_hit
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [1:0] CAUSE_BKPT = 2'd1;
   localparam logic [1:0] CAUSE_STEP = 2'd2;
   localparam logic [1:0] CAUSE_EXT  = 2'd3;

   state_t                 state;
   state_t                 state_nxt;
   logic [1:0]             cause;
   logic [1:0]             cause_nxt;

   logic                   stepping;
   logic [NUM_BKPT-1:0]    bkpt_en;
   logic [NUM_BKPT-1:0]    hit;
   logic [STEP_CNT_W-1:0]  stepcnt;
   logic [31:0]            bkpt_addr [NUM_BKPT];

   logic [9:0]             reg_idx;
   logic                   wr_en;
   logic                   wr_ctrl;
   logic                   wr_status;
   logic                   wr_stepcnt;
   logic                   resume_wr;
   logic                   halt_wr;
   logic [NUM_BKPT-1:0]    match;
   logic                   step_evt;
   logic                   step_expire;
   logic                   unused_addr_lsb;

   assign reg_idx     = apb_dbg_paddr[11:2];
   assign wr_en       = apb_dbg_psel & apb_dbg_pwrite & ~apb_dbg_penable;
   assign wr_ctrl     = wr_en & (reg_idx == 10'd0);
   assign wr_status   = wr_en & (reg_idx == 10'd1);
   assign wr_stepcnt  = wr_en & (reg_idx == 10'd2);
   assign resume_wr   = wr_ctrl & apb_dbg_pwdata[1];
   assign halt_wr     = wr_ctrl & apb_dbg_pwdata[2];

   // Byte-lane bits of the address carry no meaning for word registers.
   assign unused_addr_lsb = ^apb_dbg_paddr[1:0];

   assign dbg_apb_pready  = 1'b1;
   assign dbg_apb_pslverr = 1'b0;
   assign dbg_halt_req    = (state == HALTED);

   // Breakpoint comparators; retires are invisible while halted, bit0 of the address is a don't-care.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_BKPT; i++) begin
         match[i] = (state == RUN) & cpu_instr_valid & bkpt_en[i] &
                    (cpu_pc[31:1] == bkpt_addr[i][31:1]);
      end
   end

   assign step_evt    = (state == RUN) & stepping & cpu_instr_valid;
   assign step_expire = step_evt & (stepcnt <= STEP_CNT_W'(1));

   // Run/halt state and halt cause registers.
   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         state <= RUN;
         cause <= 2'd0;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
      end
   end

   // Next-state logic: breakpoint beats step beats external halt; cause survives resume.
   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      case (state)
         RUN: begin
            if (|match) begin
               state_nxt = HALTED;
               cause_nxt = CAUSE_BKPT;
            end else if (step_expire) begin
               state_nxt = HALTED;
               cause_nxt = CAUSE_STEP;
            end else if (halt_wr) begin
               state_nxt = HALTED;
               cause_nxt = CAUSE_EXT;
            end
         end
         HALTED: begin
            if (resume_wr) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // DBGCTRL storage; resume/halt bits are strobes and are not kept.
   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         stepping <= 1'b0;
         bkpt_en  <= '0;
      end else if (wr_ctrl) begin
         stepping <= apb_dbg_pwdata[0];
         bkpt_en  <= apb_dbg_pwdata[8 +: NUM_BKPT];
      end
   end

   // Step counter: software write overrides a same-cycle decrement; expiry parks it at zero.
   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         stepcnt <= '0;
      end else if (wr_stepcnt) begin
         stepcnt <= apb_dbg_pwdata[STEP_CNT_W-1:0];
      end else if (step_evt) begin
         stepcnt <= step_expire ? '0 : stepcnt - STEP_CNT_W'(1);
      end
   end

   // Sticky hit flags (a new hit beats a same-cycle W1C) and the one-cycle hit pulse.
   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         hit          <= '0;
         dbg_bkpt_hit <= '0;
      end else begin
         hit          <= (hit & ~(wr_status ? apb_dbg_pwdata[8 +: NUM_BKPT] : '0)) | match;
         dbg_bkpt_hit <= match;
      end
   end

   // Breakpoint address registers at word index 8+i.
   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         for (int i = 0; i < NUM_BKPT; i++) begin
            bkpt_addr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BKPT; i++) begin
            if (wr_en && (reg_idx == 10'(8 + i))) begin
               bkpt_addr[i] <= apb_dbg_pwdata;
            end
         end
      end
   end

`ifdef NANORV32_DBG_HITCNT_EN
   logic [15:0] hitcnt [NUM_BKPT];

   // Saturating hit counters at word index 16+i; any write clears, clear plus hit yields 1.
   always_ff @(posedge clk_apb or negedge rst_apb_n) begin
      if (!rst_apb_n) begin
         for (int i = 0; i < NUM_BKPT; i++) begin
            hitcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BKPT; i++) begin
            if (wr_en && (reg_idx == 10'(16 + i))) begin
               hitcnt[i] <= match[i] ? 16'd1 : 16'd0;
            end else if (match[i] && (hitcnt[i] != 16'hFFFF)) begin
               hitcnt[i] <= hitcnt[i] + 16'd1;
            end
         end
      end
   end
`endif

   // Combinational read mux; anything unmapped or unselected reads zero.
   always_comb begin
      dbg_apb_prdata = '0;
      if (apb_dbg_psel) begin
         case (reg_idx)
            10'd0: begin
               dbg_apb_prdata[0]             = stepping;
               dbg_apb_prdata[8 +: NUM_BKPT] = bkpt_en;
            end
            10'd1: begin
               dbg_apb_prdata[0]             = (state == HALTED);
               dbg_apb_prdata[3:2]           = cause;
               dbg_apb_prdata[8 +: NUM_BKPT] = hit;
            end
            10'd2: begin
               dbg_apb_prdata[STEP_CNT_W-1:0] = stepcnt;
            end
            default: begin
               for (int i = 0; i < NUM_BKPT; i++) begin
                  if (reg_idx == 10'(8 + i)) begin
                     dbg_apb_prdata = bkpt_addr[i];
                  end
`ifdef NANORV32_DBG_HITCNT_EN
                  if (reg_idx == 10'(16 + i)) begin
                     dbg_apb_prdata[15:0] = hitcnt[i];
                  end
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nanorv32_dbg_apbif.sv
// Self-checking bench for nanorv32_dbg_apbif: register table, then breakpoint/step/collision sequences.
// Expected values are pushed to a scoreboard queue before stimulus and popped when outputs are sampled.
// All inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_nanorv32_dbg_apbif;

   logic        clk_apb = 1'b0;
   logic        rst_apb_n;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        instr_valid;
   logic [31:0] pc;
   logic        halt_req;
   logic [3:0]  bkpt_hit;

   nanorv32_dbg_apbif #(.NUM_BKPT(4), .STEP_CNT_W(16)) dut (
      .clk_apb         (clk_apb),
      .rst_apb_n       (rst_apb_n),
      .apb_dbg_psel    (psel),
      .apb_dbg_paddr   (paddr),
      .apb_dbg_penable (penable),
      .apb_dbg_pwrite  (pwrite),
      .apb_dbg_pwdata  (pwdata),
      .dbg_apb_prdata  (prdata),
      .dbg_apb_pready  (pready),
      .dbg_apb_pslverr (pslverr),
      .cpu_instr_valid (instr_valid),
      .cpu_pc          (pc),
      .dbg_halt_req    (halt_req),
      .dbg_bkpt_hit    (bkpt_hit)
   );

   always #5 clk_apb = ~clk_apb;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic sb_push(input string name, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic sb_pop_cmp(input logic [31:0] act);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_underflow: got %h with no expectation queued", act);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if (act !== e.val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk_apb);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
      @(negedge clk_apb);
      penable = 1'b1;
      @(negedge clk_apb);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
      @(negedge clk_apb);
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
      @(negedge clk_apb);
      penable = 1'b1;
      #1 d = prdata;
      @(negedge clk_apb);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic rd_chk(input logic [11:0] a, input logic [31:0] e, input string name);
      logic [31:0] d;
      sb_push(name, e);
      apb_read(a, d);
      sb_pop_cmp(d);
   endtask

   task automatic sig_chk(input string name, input logic [31:0] act, input logic [31:0] e);
      sb_push(name, e);
      sb_pop_cmp(act);
   endtask

   // One retire pulse, then sample halt request and hit pulse right after the capturing edge.
   task automatic retire_chk(input logic [31:0] p, input logic e_halt, input logic [3:0] e_hit,
                             input string name);
      sb_push({name, "_halt"}, {31'd0, e_halt});
      sb_push({name, "_hit"}, {28'd0, e_hit});
      @(negedge clk_apb);
      instr_valid = 1'b1; pc = p;
      @(negedge clk_apb);
      instr_valid = 1'b0;
      #1;
      sb_pop_cmp({31'd0, halt_req});
      sb_pop_cmp({28'd0, bkpt_hit});
   endtask

   // APB write whose commit cycle coincides with a retire.
   task automatic wr_retire(input logic [11:0] a, input logic [31:0] d, input logic [31:0] p);
      @(negedge clk_apb);
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
      instr_valid = 1'b1; pc = p;
      @(negedge clk_apb);
      penable = 1'b1; instr_valid = 1'b0;
      @(negedge clk_apb);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vt[22];
      logic [31:0] rd;

      vt[0]  = '{1'b0, 12'h000, 32'h0,         32'h0000_0000, "rst_ctrl"};
      vt[1]  = '{1'b0, 12'h004, 32'h0,         32'h0000_0000, "rst_status"};
      vt[2]  = '{1'b0, 12'h008, 32'h0,         32'h0000_0000, "rst_stepcnt"};
      vt[3]  = '{1'b0, 12'h020, 32'h0,         32'h0000_0000, "rst_bkpt0"};
      vt[4]  = '{1'b0, 12'h024, 32'h0,         32'h0000_0000, "rst_bkpt1"};
      vt[5]  = '{1'b0, 12'h028, 32'h0,         32'h0000_0000, "rst_bkpt2"};
      vt[6]  = '{1'b0, 12'h02C, 32'h0,         32'h0000_0000, "rst_bkpt3"};
      vt[7]  = '{1'b0, 12'h040, 32'h0,         32'h0000_0000, "rst_hitcnt0"};
      vt[8]  = '{1'b0, 12'h100, 32'h0,         32'h0000_0000, "unmapped_rd"};
      vt[9]  = '{1'b1, 12'h008, 32'hFFFF_ABCD, 32'h0000_ABCD, "stepcnt_mask"};
      vt[10] = '{1'b1, 12'h020, 32'h1234_5679, 32'h1234_5679, "bkpt0_rw"};
      vt[11] = '{1'b1, 12'h02C, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "bkpt3_rw"};
      vt[12] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0000_0F01, "ctrl_mask"};
      vt[13] = '{1'b0, 12'h004, 32'h0,         32'h0000_000D, "ext_halt_status"};
      vt[14] = '{1'b1, 12'h004, 32'hFFFF_FFFF, 32'h0000_000D, "status_ro"};
      vt[15] = '{1'b1, 12'h000, 32'h0000_0006, 32'h0000_0000, "resume_halt_together"};
      vt[16] = '{1'b0, 12'h004, 32'h0,         32'h0000_000C, "resumed_cause_kept"};
      vt[17] = '{1'b1, 12'h100, 32'hFFFF_FFFF, 32'h0000_0000, "unmapped_wr"};
      vt[18] = '{1'b1, 12'h040, 32'h0000_0005, 32'h0000_0000, "hitcnt0_wr"};
      vt[19] = '{1'b1, 12'h008, 32'h0,         32'h0000_0000, "stepcnt_clr"};
      vt[20] = '{1'b1, 12'h020, 32'h0,         32'h0000_0000, "bkpt0_clr"};
      vt[21] = '{1'b1, 12'h02C, 32'h0,         32'h0000_0000, "bkpt3_clr"};

      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      instr_valid = 1'b0; pc = '0;
      rst_apb_n = 1'b0;
      repeat (3) @(negedge clk_apb);
      #1;
      sig_chk("rst_halt_req", {31'd0, halt_req}, 32'd0);
      sig_chk("rst_bkpt_hit", {28'd0, bkpt_hit}, 32'd0);
      sig_chk("rst_prdata_idle", prdata, 32'd0);
      rst_apb_n = 1'b1;
      sig_chk("pready", {31'd0, pready}, 32'd1);
      sig_chk("pslverr", {31'd0, pslverr}, 32'd0);

      for (int i = 0; i < 22; i++) begin
         if (vt[i].wr) apb_write(vt[i].addr, vt[i].wdata);
         sb_push(vt[i].name, vt[i].exp);
         apb_read(vt[i].addr, rd);
         sb_pop_cmp(rd);
      end

      // Breakpoint 2 hit, sticky status, halted retires ignored.
      apb_write(12'h028, 32'h0000_0100);
      apb_write(12'h000, 32'h0000_0400);
      retire_chk(32'h100, 1'b1, 4'b0100, "bkpt2");
      @(negedge clk_apb); #1;
      sig_chk("bkpt2_pulse_end", {28'd0, bkpt_hit}, 32'd0);
      rd_chk(12'h004, 32'h0000_0405, "status_bkpt2");
      retire_chk(32'h100, 1'b1, 4'b0000, "halted_ignore");
      rd_chk(12'h004, 32'h0000_0405, "status_unchanged");
      apb_write(12'h004, 32'h0000_0400);
      rd_chk(12'h004, 32'h0000_0005, "w1c_hit");
      apb_write(12'h000, 32'h0000_0402);
      #1 sig_chk("resume_halt_req", {31'd0, halt_req}, 32'd0);
      rd_chk(12'h004, 32'h0000_0004, "resume_status");
      retire_chk(32'h101, 1'b1, 4'b0100, "bit0_ignored");
      rd_chk(12'h004, 32'h0000_0405, "status_bit0");
      apb_write(12'h000, 32'h0000_0002);
      apb_write(12'h004, 32'h0000_0400);
      rd_chk(12'h004, 32'h0000_0004, "status_clean");

      // Counted stepping.
      apb_write(12'h008, 32'd3);
      apb_write(12'h000, 32'h0000_0001);
      retire_chk(32'h200, 1'b0, 4'b0, "step1");
      rd_chk(12'h008, 32'd2, "stepcnt_2");
      retire_chk(32'h204, 1'b0, 4'b0, "step2");
      rd_chk(12'h008, 32'd1, "stepcnt_1");
      retire_chk(32'h208, 1'b1, 4'b0, "step3");
      rd_chk(12'h008, 32'd0, "stepcnt_0");
      rd_chk(12'h004, 32'h0000_0009, "status_step");
      apb_write(12'h008, 32'd5);
      retire_chk(32'h20C, 1'b1, 4'b0, "halted_no_dec");
      rd_chk(12'h008, 32'd5, "stepcnt_held");
      apb_write(12'h008, 32'd0);
      apb_write(12'h000, 32'h0000_0003);
      retire_chk(32'h210, 1'b1, 4'b0, "step_zero");
      rd_chk(12'h008, 32'd0, "stepcnt_zero");
      rd_chk(12'h004, 32'h0000_0009, "status_step_zero");

      // Breakpoint and step expiry together.
      apb_write(12'h008, 32'd1);
      apb_write(12'h000, 32'h0000_0403);
      retire_chk(32'h100, 1'b1, 4'b0100, "bkpt_and_step");
      rd_chk(12'h004, 32'h0000_0405, "status_bkpt_wins");
      rd_chk(12'h008, 32'd0, "stepcnt_coincide");
      apb_write(12'h004, 32'h0000_0400);
      apb_write(12'h000, 32'h0000_0003);
      rd_chk(12'h004, 32'h0000_0004, "status_rerun");

      // STEPCNT write beats a same-cycle decrement.
      apb_write(12'h008, 32'd10);
      wr_retire(12'h008, 32'd5, 32'h300);
      sig_chk("wr_vs_dec_halt", {31'd0, halt_req}, 32'd0);
      rd_chk(12'h008, 32'd5, "stepcnt_wr_wins");
      retire_chk(32'h304, 1'b0, 4'b0, "step_after_wr");
      rd_chk(12'h008, 32'd4, "stepcnt_4");
      apb_write(12'h000, 32'h0000_0000);

      // Halt ignored while halted; new hit beats same-cycle W1C.
      apb_write(12'h020, 32'h0000_0400);
      apb_write(12'h000, 32'h0000_0100);
      retire_chk(32'h400, 1'b1, 4'b0001, "bkpt0");
      apb_write(12'h000, 32'h0000_0104);
      rd_chk(12'h004, 32'h0000_0105, "halt_when_halted");
      apb_write(12'h000, 32'h0000_0102);
      rd_chk(12'h004, 32'h0000_0104, "resumed_hit_sticky");
      wr_retire(12'h004, 32'h0000_0100, 32'h400);
      rd_chk(12'h004, 32'h0000_0105, "w1c_vs_set");
      apb_write(12'h000, 32'h0000_0002);
      apb_write(12'h004, 32'h0000_0100);
      rd_chk(12'h004, 32'h0000_0004, "status_clean2");

`ifdef NANORV32_DBG_HITCNT_EN
      apb_write(12'h040, 32'h0);
      rd_chk(12'h040, 32'd0, "hitcnt0_clr");
      apb_write(12'h020, 32'h0000_0500);
      apb_write(12'h000, 32'h0000_0100);
      for (int k = 0; k < 3; k++) begin
         retire_chk(32'h500, 1'b1, 4'b0001, "hitcnt_hit");
         apb_write(12'h000, 32'h0000_0102);
      end
      rd_chk(12'h040, 32'd3, "hitcnt0_3");
      wr_retire(12'h040, 32'h0, 32'h500);
      rd_chk(12'h040, 32'd1, "hitcnt0_clr_inc");
`else
      apb_write(12'h000, 32'h0000_0004);
      rd_chk(12'h004, 32'h0000_000D, "ext_halt2");
`endif

      // Asynchronous reset while halted.
      #1 sig_chk("pre_reset_halt", {31'd0, halt_req}, 32'd1);
      @(negedge clk_apb);
      #2 rst_apb_n = 1'b0;
      #1;
      sig_chk("async_rst_halt_req", {31'd0, halt_req}, 32'd0);
      sig_chk("async_rst_bkpt_hit", {28'd0, bkpt_hit}, 32'd0);
      @(negedge clk_apb);
      rst_apb_n = 1'b1;
      rd_chk(12'h004, 32'h0, "post_rst_status");
      rd_chk(12'h000, 32'h0, "post_rst_ctrl");
      rd_chk(12'h028, 32'h0, "post_rst_bkpt2");

      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
